mvm_row_streamer: RTL and testbench

//  Producer side of the accumulator stream interface (data/ivalid/first/last).
//  On start, walks a row-major matrix and a vector held in two sync-read RAMs.

---
 rtl/mvm_row_streamer.sv | 195 +++++++++++++++++++
 tb/tb_mvm_row_streamer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_row_streamer.sv
// Producer for the accumulator stream: walks a row-major matrix and a vector held in
// sync-read RAMs and emits one first/last-framed stream of element products per row.
module mvm_row_streamer #(
    parameter  int IWIDTH   = 8,
    parameter  int OWIDTH   = 19,
    parameter  int MAX_LEN  = 64,
    parameter  int MAX_ROWS = 64,
    localparam int LENW     = $clog2(MAX_LEN) + 1,
    localparam int ROWW     = $clog2(MAX_ROWS) + 1,
    localparam int VADDRW   = $clog2(MAX_LEN),
    localparam int MADDRW   = $clog2(MAX_LEN * MAX_ROWS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ROWW-1:0]          num_rows,
    input  logic [LENW-1:0]          vec_len,
    output logic                     busy,
    output logic                     done,
    output logic                     mat_ren,
    output logic [MADDRW-1:0]        mat_raddr,
    input  logic signed [IWIDTH-1:0] mat_rdata,
    output logic                     vec_ren,
    output logic [VADDRW-1:0]        vec_raddr,
    input  logic signed [IWIDTH-1:0] vec_rdata,
    output logic [OWIDTH-1:0]        out_data,
    output logic                     out_valid,
    output logic                     out_first,
    output logic                     out_last
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_EMPTY = 3'd4
    } state_t;

    localparam logic [LENW-1:0] LEN_MAX  = LENW'(MAX_LEN);
    localparam logic [LENW-1:0] LEN_ONE  = LENW'(1);
    localparam logic [LENW-1:0] LEN_ZERO = {LENW{1'b0}};
    localparam logic [ROWW-1:0] ROW_MAX  = ROWW'(MAX_ROWS);
    localparam logic [ROWW-1:0] ROW_ONE  = ROWW'(1);
    localparam logic [ROWW-1:0] ROW_ZERO = {ROWW{1'b0}};

    // Exact signed product, sign-extended to the stream width.
    function automatic logic [OWIDTH-1:0] mul_ext(input logic signed [IWIDTH-1:0] a,
                                                  input logic signed [IWIDTH-1:0] b);
        logic signed [2*IWIDTH-1:0] p;
        p = a * b;
        return OWIDTH'(p);
    endfunction

    state_t              state_r, state_s;
    logic [LENW-1:0]     len_r, col_r, len_sat_s;
    logic [ROWW-1:0]     rows_r, row_r, rows_sat_s;
    logic [MADDRW-1:0]   addr_r;
    logic                col_last_s, last_rd_s;
    logic                busy_r, done_r, ren_r;
    logic                v1_r, f1_r, l1_r;
    logic [OWIDTH-1:0]   out_data_r;
    logic                out_valid_r, out_first_r, out_last_r;

    assign len_sat_s  = (vec_len > LEN_MAX) ? LEN_MAX : vec_len;
    assign rows_sat_s = (num_rows > ROW_MAX) ? ROW_MAX : num_rows;
    assign col_last_s = (col_r == (len_r - LEN_ONE));
    assign last_rd_s  = col_last_s && (row_r == (rows_r - ROW_ONE));

    // Next-state logic for the job sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    if ((num_rows == ROW_ZERO) || (vec_len == LEN_ZERO)) begin
                        state_s = S_EMPTY;
                    end else begin
                        state_s = S_ISSUE;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (last_rd_s) begin
                    state_s = S_DRAIN;
                end else begin
                    state_s = S_ISSUE;
                end
            end
            // Once stage 1 is empty the output stage holds the final beat.
            S_DRAIN: begin
                if (!v1_r) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            S_DONE:  state_s = S_IDLE;
            S_EMPTY: state_s = S_DONE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register and registered control outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ren_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == S_ISSUE) || (state_s == S_DRAIN) || (state_s == S_EMPTY);
            done_r  <= (state_s == S_DONE);
            ren_r   <= (state_s == S_ISSUE);
        end
    end

    // Job parameters and read-address counters; the matrix address just counts up.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_r  <= LEN_ZERO;
            rows_r <= ROW_ZERO;
            col_r  <= LEN_ZERO;
            row_r  <= ROW_ZERO;
            addr_r <= {MADDRW{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        len_r  <= len_sat_s;
                        rows_r <= rows_sat_s;
                    end
                    col_r  <= LEN_ZERO;
                    row_r  <= ROW_ZERO;
                    addr_r <= {MADDRW{1'b0}};
                end
                S_ISSUE: begin
                    addr_r <= addr_r + {{(MADDRW-1){1'b0}}, 1'b1};
                    if (col_last_s) begin
                        col_r <= LEN_ZERO;
                        row_r <= row_r + ROW_ONE;
                    end else begin
                        col_r <= col_r + LEN_ONE;
                    end
                end
                default: begin
                    col_r <= col_r;
                end
            endcase
        end
    end

    // Stage 1 carries valid/first/last alongside the RAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r <= 1'b0;
            f1_r <= 1'b0;
            l1_r <= 1'b0;
        end else begin
            v1_r <= ren_r;
            f1_r <= ren_r && (col_r == LEN_ZERO);
            l1_r <= ren_r && col_last_s;
        end
    end

    // Output stage: registered product, forced to zero when no beat is present.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_r  <= {OWIDTH{1'b0}};
            out_valid_r <= 1'b0;
            out_first_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            out_data_r  <= v1_r ? mul_ext(mat_rdata, vec_rdata) : {OWIDTH{1'b0}};
            out_valid_r <= v1_r;
            out_first_r <= f1_r;
            out_last_r  <= l1_r;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign mat_ren   = ren_r;
    assign vec_ren   = ren_r;
    assign mat_raddr = addr_r;
    assign vec_raddr = col_r[VADDRW-1:0];
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_first = out_first_r;
    assign out_last  = out_last_r;

endmodule

// File: tb/tb_mvm_row_streamer.sv
// Scoreboard bench for mvm_row_streamer: behavioural RAMs, a row-major product model,
// an accumulator-style monitor that sums each frame, and per-job timing checks.
module tb_mvm_row_streamer;

    localparam int IW   = 8;
    localparam int OW   = 19;
    localparam int ML   = 64;
    localparam int MR   = 64;
    localparam int LENW = 7;
    localparam int ROWW = 7;
    localparam int VAW  = 6;
    localparam int MAW  = 12;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [ROWW-1:0]      num_rows = '0;
    logic [LENW-1:0]      vec_len = '0;
    logic                 busy, done, mat_ren, vec_ren;
    logic [MAW-1:0]       mat_raddr;
    logic [VAW-1:0]       vec_raddr;
    logic signed [IW-1:0] mat_rdata = '0;
    logic signed [IW-1:0] vec_rdata = '0;
    logic [OW-1:0]        out_data;
    logic                 out_valid, out_first, out_last;

    logic signed [IW-1:0] mat_mem [0:ML*MR-1];
    logic signed [IW-1:0] vec_mem [0:ML-1];

    typedef struct {
        logic [OW-1:0] data;
        bit            first;
        bit            last;
    } beat_t;

    beat_t exp_q[$];
    int    dot_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    acc = 0;

    mvm_row_streamer dut (
        .clk(clk), .rst(rst), .start(start), .num_rows(num_rows), .vec_len(vec_len),
        .busy(busy), .done(done),
        .mat_ren(mat_ren), .mat_raddr(mat_raddr), .mat_rdata(mat_rdata),
        .vec_ren(vec_ren), .vec_raddr(vec_raddr), .vec_rdata(vec_rdata),
        .out_data(out_data), .out_valid(out_valid), .out_first(out_first), .out_last(out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read RAM models.
    always @(posedge clk) begin
        if (mat_ren) mat_rdata <= mat_mem[mat_raddr];
        if (vec_ren) vec_rdata <= vec_mem[vec_raddr];
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops expected beats and sums frames like the downstream accumulator.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got data %0h at cycle %0d, expected none", out_data, cyc);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_first !== e.first || out_last !== e.last) begin
                        errors++;
                        $display("FAIL beat: got %0h f%0b l%0b, expected %0h f%0b l%0b",
                                 out_data, out_first, out_last, e.data, e.first, e.last);
                    end
                end
                if (out_first) acc = int'($signed(out_data));
                else acc = acc + int'($signed(out_data));
                if (out_last) begin
                    checks++;
                    if (dot_q.size() == 0) begin
                        errors++;
                        $display("FAIL dot_product: got %0d, expected no row", acc);
                    end else begin
                        int d;
                        d = dot_q.pop_front();
                        if (acc != d) begin
                            errors++;
                            $display("FAIL dot_product: got %0d, expected %0d", acc, d);
                        end
                    end
                end
            end else if (out_data !== '0 || out_first !== 1'b0 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL idle_outputs: got data %0h f%0b l%0b, expected zeros", out_data, out_first, out_last);
            end
        end
    end

    task automatic fill_rand(input int rows, input int len);
        for (int i = 0; i < rows * len; i++) mat_mem[i] = IW'($urandom_range(0, 255));
        for (int c = 0; c < len; c++) vec_mem[c] = IW'($urandom_range(0, 255));
    endtask

    task automatic run_job(input int rows_in, input int len_in, input bit poke, input bit do_rst);
        int er, el, n, t0, first_cyc, done_cyc, reads, beats, busy_low, addr_bad, spur;
        er = (rows_in > MR) ? MR : rows_in;
        el = (len_in > ML) ? ML : len_in;
        n  = er * el;
        if (n == 0) er = 0;
        for (int r = 0; r < er; r++) begin
            int dot;
            dot = 0;
            for (int c = 0; c < el; c++) begin
                int p;
                beat_t b;
                p = int'(mat_mem[r*el + c]) * int'(vec_mem[c]);
                dot += p;
                b.data  = OW'(p);
                b.first = (c == 0);
                b.last  = (c == el - 1);
                exp_q.push_back(b);
            end
            dot_q.push_back(dot);
        end

        @(negedge clk);
        num_rows = ROWW'(rows_in);
        vec_len  = LENW'(len_in);
        start    = 1'b1;
        t0 = cyc;
        reads = 0; beats = 0; busy_low = 0; addr_bad = 0;
        first_cyc = -1; done_cyc = -1;
        for (int k = 0; k < n + 40; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (poke && k == 3) begin
                start    = 1'b1;
                num_rows = ROWW'($urandom_range(1, 8));
                vec_len  = LENW'($urandom_range(1, 16));
            end
            if (poke && k == 4) start = 1'b0;
            if (mat_ren || vec_ren) begin
                if (mat_ren !== vec_ren || mat_raddr !== MAW'(reads) ||
                    vec_raddr !== VAW'((el > 0) ? (reads % el) : 0)) addr_bad++;
                reads++;
            end
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                beats++;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (!busy) busy_low++;
            if (do_rst && beats == 2) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_out_valid", out_valid, 0);
                chk("rst_out_data", out_data, 0);
                chk("rst_busy", busy, 0);
                chk("rst_ren", mat_ren | vec_ren, 0);
                exp_q.delete();
                dot_q.delete();
                spur = 0;
                for (int j = 0; j < 12; j++) begin
                    @(negedge clk);
                    if (done || out_valid || mat_ren || busy) spur++;
                end
                chk("abort_quiet_cycles", spur, 0);
                return;
            end
        end
        chk("done_cycle", done_cyc, (n == 0) ? t0 + 2 : t0 + 3 + n);
        chk("read_count", reads, n);
        chk("read_addr_errors", addr_bad, 0);
        chk("beat_count", beats, n);
        if (n > 0) chk("first_beat_cycle", first_cyc, t0 + 3);
        chk("busy_low_cycles", busy_low, 0);
        chk("busy_at_done", busy, 0);
        #1;
        chk("beats_left", exp_q.size(), 0);
        chk("rows_left", dot_q.size(), 0);
        @(negedge clk);
        chk("done_pulse_width", done, 0);
    endtask

    initial begin
        for (int i = 0; i < ML * MR; i++) mat_mem[i] = '0;
        for (int i = 0; i < ML; i++) vec_mem[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_ren", mat_ren | vec_ren, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_data", out_data, 0);
        chk("reset_flags", out_first | out_last, 0);
        chk("reset_maddr", mat_raddr, 0);
        rst = 1'b0;

        // 2x3 matrix, rows dot to 5 and 11
        for (int i = 0; i < 6; i++) mat_mem[i] = IW'(i + 1);
        vec_mem[0] = 8'sd1; vec_mem[1] = -8'sd1; vec_mem[2] = 8'sd2;
        run_job(2, 3, 1'b0, 1'b0);

        // single-column rows: first and last on the same beat
        mat_mem[0] = 8'sd7; mat_mem[1] = -8'sd3; mat_mem[2] = 8'sd0; vec_mem[0] = 8'sd2;
        run_job(3, 1, 1'b0, 1'b0);

        // operand extremes
        mat_mem[0] = -8'sd128; mat_mem[1] = -8'sd128;
        vec_mem[0] = -8'sd128; vec_mem[1] = 8'sd127;
        run_job(1, 2, 1'b0, 1'b0);

        // empty jobs
        run_job(0, 3, 1'b0, 1'b0);
        run_job(2, 0, 1'b0, 1'b0);

        // start and size changes mid-job are ignored
        fill_rand(3, 6);
        run_job(3, 6, 1'b1, 1'b0);

        // abort after the second beat, then a clean job
        fill_rand(1, 5);
        run_job(1, 5, 1'b0, 1'b1);
        fill_rand(2, 4);
        run_job(2, 4, 1'b0, 1'b0);

        // saturation of oversized lengths and row counts
        fill_rand(1, ML);
        run_job(1, 70, 1'b0, 1'b0);
        fill_rand(MR, 1);
        run_job(MR + 1, 1, 1'b0, 1'b0);

        for (int j = 0; j < 20; j++) begin
            int r, l;
            r = $urandom_range(1, 8);
            l = $urandom_range(1, 16);
            fill_rand(r, l);
            run_job(r, l, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
